// File: rtl/pwm_demod.sv
// PWM receive demodulator: recovers a LEVEL_W-bit sample per 2^LEVEL_W-clock frame.
// Flags dead input (stuck) and frames of the wrong length (period_err).
module pwm_demod #(
  parameter int LEVEL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_in,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic               stuck,
  output logic               period_err
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK
  } state_e;

  localparam logic [LEVEL_W:0] FRAME = {1'b1, {LEVEL_W{1'b0}}};
  localparam logic [LEVEL_W:0] TMO   = '1;
  localparam logic [LEVEL_W:0] ONE   = {{LEVEL_W{1'b0}}, 1'b1};

  state_e             state_q;
  logic               s1_q;
  logic               s2_q;
  logic               prev_q;
  logic [LEVEL_W:0]   period_q;
  logic [LEVEL_W:0]   high_q;
  logic [LEVEL_W-1:0] level_q;
  logic               valid_q;
  logic               stuck_q;
  logic               err_q;

  logic               edge_d;
  logic [LEVEL_W-1:0] clamp_d;
  logic [LEVEL_W-1:0] fill_d;

  assign edge_d  = s2_q & ~prev_q;
  assign clamp_d = high_q[LEVEL_W] ? '1 : high_q[LEVEL_W-1:0];
  assign fill_d  = s2_q ? '1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q    <= pwm_in;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (edge_d) begin
            period_q <= ONE;
            high_q   <= ONE;
            state_q  <= MEASURE;
          end else if (period_q == TMO) begin
            state_q  <= STUCK;
            stuck_q  <= 1'b1;
            level_q  <= fill_d;
            valid_q  <= 1'b1;
            period_q <= ONE;
          end else begin
            period_q <= period_q + ONE;
          end
        end
        MEASURE: begin
          if (edge_d) begin
            if (period_q == FRAME) begin
              level_q <= clamp_d;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            period_q <= ONE;
            high_q   <= ONE;
          end else if (period_q == TMO) begin
            state_q  <= STUCK;
            stuck_q  <= 1'b1;
            level_q  <= fill_d;
            valid_q  <= 1'b1;
            period_q <= ONE;
          end else begin
            period_q <= period_q + ONE;
            high_q   <= high_q + {{LEVEL_W{1'b0}}, s2_q};
          end
        end
        STUCK: begin
          // An edge restarts measurement; the level only follows a full frame.
          if (edge_d) begin
            stuck_q  <= 1'b0;
            period_q <= ONE;
            high_q   <= ONE;
            state_q  <= MEASURE;
          end else if (period_q == FRAME) begin
            level_q  <= fill_d;
            valid_q  <= 1'b1;
            period_q <= ONE;
          end else begin
            period_q <= period_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign level       = level_q;
  assign level_valid = valid_q;
  assign stuck       = stuck_q;
  assign period_err  = err_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Randomised bench for pwm_demod against an edge-timing reference model.
// The model works from the list of synchronised rising edges and their gaps.
module tb_pwm_demod;

  logic       clk;
  logic       rst;
  logic       pwm_in;
  logic [7:0] level;
  logic       level_valid;
  logic       stuck;
  logic       period_err;

  pwm_demod #(.LEVEL_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .level       (level),
    .level_valid (level_valid),
    .stuck       (stuck),
    .period_err  (period_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  bit p [0:32767];
  int c;
  int last_e;
  int m_level;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0d want %0d", tag, c, obs, exp);
    end
  endtask

  function automatic bit pv(input int k);
    return (k >= 1) ? p[k] : 1'b0;
  endfunction

  // Expected outputs after posedge c, from edge times and high-time sums.
  task automatic cyc(input bit v);
    int ref_t;
    int sum;
    bit s2;
    bit e;
    bit in_stuck;
    bit x_valid;
    bit x_err;
    bit x_stuck;
    pwm_in = v;
    @(posedge clk);
    c++;
    p[c] = v;
    ref_t    = (last_e != 0) ? last_e : 1;
    s2       = pv(c - 2);
    e        = s2 & ~pv(c - 3);
    in_stuck = (c > ref_t + 511);
    x_valid  = 1'b0;
    x_err    = 1'b0;
    x_stuck  = in_stuck;
    if (e) begin
      if (last_e != 0 && !in_stuck) begin
        if (c - last_e == 256) begin
          sum = 0;
          for (int k = last_e; k < c; k++) sum += pv(k - 2);
          m_level = (sum > 255) ? 255 : sum;
          x_valid = 1'b1;
        end else begin
          x_err = 1'b1;
        end
      end
      last_e  = c;
      x_stuck = 1'b0;
    end else if (c >= ref_t + 511 && ((c - ref_t - 511) % 256) == 0) begin
      m_level = s2 ? 255 : 0;
      x_valid = 1'b1;
      x_stuck = 1'b1;
    end
    #1;
    chk("level", level, m_level);
    chk("level_valid", level_valid, x_valid);
    chk("stuck", stuck, x_stuck);
    chk("period_err", period_err, x_err);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_valid", level_valid, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_err", period_err, 0);
    repeat (n) @(negedge clk);
    rst     = 1'b1;
    c       = 0;
    last_e  = 0;
    m_level = 0;
  endtask

  task automatic frames(input int l, input int per, input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < per; i++) cyc(i < l);
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  initial begin
    int lv;
    int pr;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b0;
    pwm_in = 1'b0;
    @(negedge clk);
    do_reset(2);
    frames(128, 256, 10);
    frames(1, 256, 3);
    frames(37, 256, 3);
    frames(200, 256, 3);
    frames(255, 256, 3);
    for (int i = 0; i < 4; i++) begin
      lv = $urandom_range(1, 255);
      frames(lv, 256, 3);
    end
    do_reset(1);
    hold(1'b0, 1000);
    frames(64, 256, 4);
    frames(50, 256, 4);
    hold(1'b1, 1000);
    frames(90, 256, 3);
    do_reset(1);
    frames(100, 200, 8);
    for (int i = 0; i < 10; i++) begin
      pr = ($urandom_range(0, 2) == 0) ? $urandom_range(120, 400) : 256;
      lv = $urandom_range(1, pr - 1);
      frames(lv, pr, 2);
    end
    frames(128, 256, 3);
    for (int i = 0; i < 150; i++) cyc(i < 128);
    do_reset(3);
    for (int i = 153; i < 256; i++) cyc(1'b0);
    frames(128, 256, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
